// File: rtl/mux2_arbiter.sv
// rtl/mux2_arbiter.sv - two-requester round-robin burst arbiter driving a shared data mux
//
// Parameters:
//   DATA_W    - width of each data path
//   MAX_BURST - maximum beats per grant (1..15)
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   din_0, din_1      - requester data
//   vld_0, vld_1      - requester has a beat
//   last_0, last_1    - current beat ends the requester's burst
//   rdy_0, rdy_1      - beat from that requester accepted this cycle
//   mux_out, out_vld  - selected data and its valid
//   out_rdy           - downstream accepts the beat
//   sel               - current mux select (0 = din_0, 1 = din_1)
//   busy              - a grant is active

module mux2_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din_0,
    input  logic [DATA_W-1:0] din_1,
    input  logic              vld_0,
    input  logic              vld_1,
    input  logic              last_0,
    input  logic              last_1,
    output logic              rdy_0,
    output logic              rdy_1,
    output logic [DATA_W-1:0] mux_out,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              sel,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    logic [1:0] state, state_nxt;
    logic       sel_nxt;
    logic       busy_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       last_served, last_served_nxt;

    logic       gnt0, gnt1;
    logic       xfer;
    logic       cur_last;
    logic       other_vld;
    logic [3:0] cnt_inc;
    logic       burst_end;
    logic       pick;

    assign gnt0 = (state == GNT0);
    assign gnt1 = (state == GNT1);

    assign mux_out = sel ? din_1 : din_0;
    assign out_vld = (gnt0 & vld_0) | (gnt1 & vld_1);
    assign rdy_0   = gnt0 & vld_0 & out_rdy;
    assign rdy_1   = gnt1 & vld_1 & out_rdy;

    assign xfer      = out_vld & out_rdy;
    assign cur_last  = gnt1 ? last_1 : last_0;
    assign other_vld = gnt1 ? vld_0 : vld_1;
    assign cnt_inc   = cnt + 4'd1;
    assign burst_end = xfer & (cur_last | (cnt_inc >= BURST_MAX));

    // Requester picked from IDLE: on a tie, the one not served last; 1 means requester 1.
    assign pick = (vld_0 & vld_1) ? ~last_served : vld_1;

    always_comb begin
        state_nxt       = state;
        sel_nxt         = sel;
        busy_nxt        = busy;
        cnt_nxt         = cnt;
        last_served_nxt = last_served;
        case (state)
            IDLE: begin
                if (vld_0 || vld_1) begin
                    state_nxt = pick ? GNT1 : GNT0;
                    sel_nxt   = pick;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = 4'd0;
                end
            end
            GNT0, GNT1: begin
                if (burst_end) begin
                    last_served_nxt = gnt1;
                    cnt_nxt         = 4'd0;
                    // Hand straight over to a waiting peer; otherwise park in IDLE with sel held.
                    if (other_vld) begin
                        state_nxt = gnt1 ? GNT0 : GNT1;
                        sel_nxt   = gnt0;
                    end else begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                    end
                end else if (xfer) begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel         <= 1'b0;
            busy        <= 1'b0;
            cnt         <= 4'd0;
            last_served <= 1'b1;
        end else begin
            state       <= state_nxt;
            sel         <= sel_nxt;
            busy        <= busy_nxt;
            cnt         <= cnt_nxt;
            last_served <= last_served_nxt;
        end
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// tb/tb_mux2_arbiter.sv - self-checking bench for mux2_arbiter (MAX_BURST 4 and 1 instances)

module tb_mux2_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din_0 = 8'h00, din_1 = 8'h00;
    logic       vld_0 = 1'b0, vld_1 = 1'b0;
    logic       last_0 = 1'b0, last_1 = 1'b0;
    logic       out_rdy = 1'b0;

    logic [1:0] rdy_0_o, rdy_1_o, out_vld_o, sel_o, busy_o;
    logic [7:0] mux_o [2];

    int n_chk  = 0;
    int n_fail = 0;
    int rst_cnt = 0;

    always #5 clk = ~clk;

    mux2_arbiter #(.DATA_W(8), .MAX_BURST(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .din_0(din_0), .din_1(din_1),
        .vld_0(vld_0), .vld_1(vld_1), .last_0(last_0), .last_1(last_1),
        .rdy_0(rdy_0_o[0]), .rdy_1(rdy_1_o[0]), .mux_out(mux_o[0]),
        .out_vld(out_vld_o[0]), .out_rdy(out_rdy), .sel(sel_o[0]), .busy(busy_o[0])
    );

    mux2_arbiter #(.DATA_W(8), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .din_0(din_0), .din_1(din_1),
        .vld_0(vld_0), .vld_1(vld_1), .last_0(last_0), .last_1(last_1),
        .rdy_0(rdy_0_o[1]), .rdy_1(rdy_1_o[1]), .mux_out(mux_o[1]),
        .out_vld(out_vld_o[1]), .out_rdy(out_rdy), .sel(sel_o[1]), .busy(busy_o[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge rst_n) rst_cnt++;

    // Reference model: owner (-1 none), beats taken in this grant, requester served last, select.
    int owner [2];
    int beats [2];
    int prior [2];
    int msel  [2];
    int maxb  [2] = '{4, 1};
    int rst_seen = 0;

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            owner[m] = -1; beats[m] = 0; prior[m] = 1; msel[m] = 0;
        end
    endtask

    task automatic model_step();
        int v [2];
        int l [2];
        int k;
        v[0] = int'(vld_0);  v[1] = int'(vld_1);
        l[0] = int'(last_0); l[1] = int'(last_1);
        for (int m = 0; m < 2; m++) begin
            if (owner[m] < 0) begin
                if (v[0] == 1 && v[1] == 1) owner[m] = 1 - prior[m];
                else if (v[0] == 1)         owner[m] = 0;
                else if (v[1] == 1)         owner[m] = 1;
                if (owner[m] >= 0) msel[m] = owner[m];
                beats[m] = 0;
            end else begin
                k = owner[m];
                if (v[k] == 1 && out_rdy) begin
                    beats[m]++;
                    if (l[k] == 1 || beats[m] == maxb[m]) begin
                        prior[m] = k;
                        beats[m] = 0;
                        if (v[1-k] == 1) begin
                            owner[m] = 1 - k;
                            msel[m]  = 1 - k;
                        end else begin
                            owner[m] = -1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic model_compare();
        int  o;
        logic ev;
        for (int m = 0; m < 2; m++) begin
            o  = owner[m];
            ev = (o == 0) ? vld_0 : (o == 1) ? vld_1 : 1'b0;
            chk($sformatf("m%0d sel", m),     32'(sel_o[m]),     32'(msel[m]));
            chk($sformatf("m%0d busy", m),    32'(busy_o[m]),    32'(o >= 0));
            chk($sformatf("m%0d out_vld", m), 32'(out_vld_o[m]), 32'(ev));
            chk($sformatf("m%0d rdy_0", m),   32'(rdy_0_o[m]),   32'(o == 0 && vld_0 && out_rdy));
            chk($sformatf("m%0d rdy_1", m),   32'(rdy_1_o[m]),   32'(o == 1 && vld_1 && out_rdy));
            chk($sformatf("m%0d mux_out", m), 32'(mux_o[m]),     32'(msel[m] == 1 ? din_1 : din_0));
        end
    endtask

    bit run_model = 1'b1;

    initial begin
        model_reset();
        while (run_model) begin
            @(negedge clk);
            #2;
            if (!rst_n) model_reset();
            model_compare();
            @(posedge clk);
            if (!rst_n || rst_seen != rst_cnt) model_reset();
            rst_seen = rst_cnt;
            if (rst_n) model_step();
        end
    end

    function automatic int code(input int m);
        return rdy_0_o[m] ? 1 : (rdy_1_o[m] ? 2 : 0);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_in(input logic v0, input logic v1, input logic l0, input logic l1, input logic r);
        vld_0 = v0; vld_1 = v1; last_0 = l0; last_1 = l1; out_rdy = r;
    endtask

    initial begin
        int e4 [13] = '{0, 1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};
        int e1 [13] = '{0, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2};
        int e33 [8] = '{0, 1, 1, 2, 2, 2, 2, 1};
        int e34 [9] = '{0, 1, 1, 0, 0, 0, 1, 1, 2};
        int e35 [7] = '{0, 1, 1, 1, 1, 2, 2};
        int e32 [10] = '{0, 2, 2, 2, 2, 0, 2, 2, 2, 2};

        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #3;
        chk("reset sel", 32'(sel_o), 32'd0);
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset out_vld", 32'(out_vld_o), 32'd0);

        // Both requesters, no last: 4-beat alternation, and 1-beat alternation for MAX_BURST=1.
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        din_0 = 8'h11; din_1 = 8'h22;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            #3;
            chk($sformatf("rr4 cyc%0d", i), 32'(code(0)), 32'(e4[i]));
            chk($sformatf("rr1 cyc%0d", i), 32'(code(1)), 32'(e1[i]));
            @(negedge clk);
        end

        // Single requester 1.
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        din_0 = 8'hA5; din_1 = 8'h3C;
        do_reset();
        #3;
        chk("solo mux pre", 32'(mux_o[0]), 32'h0A5);
        chk("solo sel pre", 32'(sel_o[0]), 32'd0);
        @(negedge clk);
        #3;
        chk("solo sel", 32'(sel_o[0]), 32'd1);
        chk("solo mux", 32'(mux_o[0]), 32'h03C);
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 10; i++) begin
            #3;
            chk($sformatf("solo seq%0d", i), 32'(code(0)), 32'(e32[i]));
            chk("solo rdy_0", 32'(rdy_0_o[0]), 32'd0);
            @(negedge clk);
        end

        // Early last on beat 2 of requester 0.
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            last_0 = (i == 2);
            #3;
            chk($sformatf("last cyc%0d", i), 32'(code(0)), 32'(e33[i]));
            @(negedge clk);
        end

        // Downstream stall mid-burst.
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 9; i++) begin
            out_rdy = !(i >= 3 && i <= 5);
            #3;
            chk($sformatf("stall cyc%0d", i), 32'(code(0)), 32'(e34[i]));
            if (i >= 3 && i <= 5) begin
                chk("stall sel", 32'(sel_o[0]), 32'd0);
                chk("stall out_vld", 32'(out_vld_o[0]), 32'd1);
            end
            @(negedge clk);
        end

        // Asynchronous reset pulse during GNT1 beat 2.
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 7; i++) begin
            #3;
            chk($sformatf("arst cyc%0d", i), 32'(code(0)), 32'(e35[i]));
            if (i < 6) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("arst sel", 32'(sel_o[0]), 32'd0);
        chk("arst busy", 32'(busy_o), 32'd0);
        chk("arst rdy_1", 32'(rdy_1_o[0]), 32'd0);
        chk("arst out_vld", 32'(out_vld_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #3;
        chk("arst regrant", 32'(code(0)), 32'd1);
        chk("arst regrant sel", 32'(sel_o[0]), 32'd0);

        // Randomized traffic, stalls and occasional asynchronous reset pulses.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            vld_0   = ($urandom_range(0, 9) < 7);
            vld_1   = ($urandom_range(0, 9) < 7);
            last_0  = ($urandom_range(0, 9) < 2);
            last_1  = ($urandom_range(0, 9) < 2);
            out_rdy = ($urandom_range(0, 3) != 0);
            din_0   = 8'($urandom);
            din_1   = 8'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                #3 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        @(negedge clk);
        run_model = 1'b0;
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of each data path.
REQ-002 SHALL have parameter MAX_BURST, default 4, legal range 1..15: maximum beats per grant.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports din_0 and din_1, input, DATA_W bits each: requester data.
REQ-006 SHALL have ports vld_0 and vld_1, input, 1 bit each: requester has a beat.
REQ-007 SHALL have ports last_0 and last_1, input, 1 bit each: the current beat ends the requester's burst.
REQ-008 SHALL have ports rdy_0 and rdy_1, output, 1 bit each: the beat from that requester is accepted this cycle.
REQ-009 SHALL have port mux_out, output, DATA_W bits: selected data.
REQ-010 SHALL have port out_vld, output, 1 bit: mux_out carries a valid beat.
REQ-011 SHALL have port out_rdy, input, 1 bit: the downstream consumer accepts the beat.
REQ-012 SHALL have port sel, output, 1 bit: current mux select (0 = din_0, 1 = din_1).
REQ-013 SHALL have port busy, output, 1 bit: a grant is active.

Function
REQ-014 SHALL implement a state machine with states IDLE, GNT0 and GNT1; sel, busy and the beat counter SHALL be registered.
REQ-015 SHALL drive mux_out = sel ? din_1 : din_0 combinationally, in every state.
REQ-016 SHALL drive out_vld = (GNT0 & vld_0) | (GNT1 & vld_1), and SHALL drive out_vld = 0 in IDLE.
REQ-017 SHALL drive rdy_0 = GNT0 & vld_0 & out_rdy and rdy_1 = GNT1 & vld_1 & out_rdy; the non-granted rdy SHALL be 0.
REQ-018 SHALL define a transfer as out_vld & out_rdy in a cycle; only a transfer increments the beat counter.
REQ-019 In IDLE with only vld_k high, the block SHALL move to GNTk on the next edge (one-cycle grant latency), setting sel = k.
REQ-020 In IDLE with both vld high, the block SHALL grant the requester not recorded in last_served (round-robin).
REQ-021 In GNTk, a transfer with last_k = 1, or a transfer that brings the beat count to MAX_BURST, SHALL release the grant; last_served SHALL become k and the counter SHALL clear.
REQ-022 On release, if the other requester's vld is high in that cycle, the block SHALL go directly to the other GNT state with no IDLE cycle; otherwise it SHALL go to IDLE.
REQ-023 On release with only vld_k still high, the block SHALL go to IDLE and re-grant k on the following edge.
REQ-024 A granted requester dropping vld mid-burst SHALL NOT release the grant; out_vld SHALL be 0 until vld returns (no timeout).
REQ-025 Holding out_rdy = 0 SHALL freeze state, counter and sel.
REQ-026 sel SHALL change only on a state transition into GNT0 or GNT1, and SHALL hold its value in IDLE.
REQ-027 The beat counter SHALL be 4 bits wide and SHALL never exceed MAX_BURST.

Reset
REQ-028 rst_n = 0 SHALL immediately, without waiting for clk, force: state IDLE, sel = 0, busy = 0, counter = 0, last_served = 1. This makes requester 0 win the first tie; out_vld, rdy_0 and rdy_1 then evaluate to 0.
REQ-029 Reset asserted mid-burst SHALL abandon the burst with no further rdy pulses; after deassertion, arbitration SHALL restart per REQ-019/020.
REQ-030 Deassertion of rst_n SHALL be honoured on the first clk edge after release, with no extra idle cycles.

Verification
REQ-031 Reset, then vld_0 = vld_1 = 1 with last_0 = last_1 = 0 and out_rdy = 1 held -> GNT0 after 1 cycle, 4 rdy_0 pulses, then GNT1 directly, 4 rdy_1 pulses, then GNT0; sel toggles every 4 beats.
REQ-032 din_0 = 8'hA5, din_1 = 8'h3C, vld_1 only -> sel = 1 after 1 cycle, mux_out = 8'h3C, rdy_0 never asserted.
REQ-033 GNT0 with last_0 = 1 on beat 2 while vld_1 = 1 -> release after 2 beats, GNT1 next cycle, counter restarts at 0.
REQ-034 out_rdy = 0 for 3 cycles mid-burst -> no rdy pulses, counter and sel unchanged; burst resumes when out_rdy returns to 1.
REQ-035 rst_n pulsed low between edges during GNT1 beat 2 -> sel = 0 and busy = 0 immediately; after release with vld_0 = vld_1 = 1, requester 0 is granted first.
REQ-036 MAX_BURST = 1, both requesters active -> grants alternate every beat (0,1,0,1) with no IDLE cycles.
